hop_scan_ctrl: RTL and testbench
================================

Name: hop_scan_ctrl

Overview:
- Serial scan-chain loader for the tag chip's hop code.
- Once per reset release it captures a parallel code word and shifts its low NTX_BITS bits into the chip. Shifting is MSB first, using a two-phase non-overlapping clock (scan_phi / scan_phi_bar), then pulses scan_load_chip.
- It runs on the divided scan clock. The upstream hop sequencer pulses reset once per frequency hop to reload a new code.

Parameters:
- SCAN_WIDTH, 2: clock cycles per scan sub-phase (≥1).
- NTX_BITS, 78: number of bits shifted per load (1..TX_BITS_WIDTH, < 2^BIT_CNT_WIDTH).
- TX_BITS_WIDTH, 128: width of data_in.
- BIT_CNT_WIDTH, 7: width of nbits_cnt.

Ports:
- clk, input, 1: scan clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- data_in, input, TX_BITS_WIDTH: code word; bits [NTX_BITS-1:0] are used.
- scan_id, output, 1: scan enable; high while bits are being shifted.
- scan_phi, output, 1: scan clock phase 1.
- scan_phi_bar, output, 1: scan clock phase 2.
- scan_data_in, output, 1: serial data to the chip.
- scan_load_chip, output, 1: latch-into-chip strobe.
- nbits_cnt, output, BIT_CNT_WIDTH: number of bits fully shifted so far.
- scan_done, output, 1: load sequence complete.

Behaviour:
- All outputs are registered. W = SCAN_WIDTH, N = NTX_BITS.
- Reset (reset=0, asynchronous):
  - All outputs go to 0 immediately; nbits_cnt = 0.
  - State is CAPTURE; the phase counter is cleared.
  - Asserting reset mid-operation aborts the sequence. A full restart follows release.
- States: CAPTURE → SHIFT → LOAD → DONE.
- CAPTURE, first rising edge after release:
  - Shift register <= data_in[N-1:0].
  - scan_id <= 1, scan_data_in <= data_in[N-1], state <= SHIFT (sub-phase 0).
- SHIFT: each bit k (0..N-1) occupies 4W cycles in four sub-phases of W cycles each:
  - P0 setup: phi=0, phi_bar=0.
  - P1: phi=1.
  - P2 gap: both low.
  - P3: phi_bar=1.
  - scan_data_in holds bit N-1-k for all 4W cycles and changes only on the P3→P0 boundary.
  - phi and phi_bar are never high in the same cycle.
  - nbits_cnt = k during bit k. It increments on the last cycle of P3, so it equals N once shifting ends.
- LOAD, after bit N-1 completes:
  - scan_id=0, scan_data_in=0, phi=phi_bar=0.
  - scan_load_chip=1 for exactly W cycles.
- DONE:
  - scan_done=1; all scan outputs 0; nbits_cnt holds N.
  - Remains here until reset. There is no self-restart.
- Timing:
  - Total from first edge after release to scan_done=1 is 1 + 4W·N + W cycles (627 for defaults).
  - scan_id is high for exactly 4W·N cycles (624 for defaults).
- data_in changes after CAPTURE have no effect until the next reset.
- Bits of data_in above N-1 are ignored.

Test Plan:
- Defaults, data_in = 0xA5A5_A5A5 (zero-extended):
  - Capture scan_data_in at each scan_phi rising edge → 78 bits. The first 46 bits are 0, followed by bits 31..0 of 0xA5A5A5A5 MSB first.
  - Exactly one scan_load_chip pulse of 2 cycles, then scan_done=1 at cycle 627.
- Defaults, any data:
  - phi and phi_bar are never simultaneously 1.
  - Each phi and each phi_bar pulse is 2 cycles wide.
  - 78 phi pulses and 78 phi_bar pulses in total.
  - nbits_cnt steps 0→78 monotonically.
- SCAN_WIDTH=1, NTX_BITS=4, data_in = 4'b1011:
  - Serial bits are 1,0,1,1.
  - scan_id is high for 16 cycles; scan_load_chip is high for 1 cycle.
  - scan_done rises on edge 1+16+1 = 18.
- Reset asserted at cycle 300 of a default run, released 5 cycles later with data_in = 0x1:
  - All outputs are 0 immediately on assertion.
  - The sequence restarts from CAPTURE; the first 77 bits are 0 and the last bit is 1.
- data_in toggled every cycle after CAPTURE → the shifted stream equals the word captured on the first edge after release.
- Reset held low with clk running → all outputs stay 0 and nbits_cnt = 0.

Source files
------------

// File: rtl/hop_scan_ctrl.sv
// hop_scan_ctrl: captures a hop code word after reset release, shifts it
// MSB first through a two-phase scan clock, then strobes it into the chip.
module hop_scan_ctrl #(
    parameter int SCAN_WIDTH    = 2,
    parameter int NTX_BITS      = 78,
    parameter int TX_BITS_WIDTH = 128,
    parameter int BIT_CNT_WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TX_BITS_WIDTH-1:0] data_in,
    output logic                     scan_id,
    output logic                     scan_phi,
    output logic                     scan_phi_bar,
    output logic                     scan_data_in,
    output logic                     scan_load_chip,
    output logic [BIT_CNT_WIDTH-1:0] nbits_cnt,
    output logic                     scan_done
);

    localparam int CW = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_WIDTH - 1);
    localparam logic [CW-1:0] CYC_ONE = CW'(1);
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT =
        BIT_CNT_WIDTH'(NTX_BITS - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] CNT_ONE = BIT_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_CAPTURE,
        S_SHIFT,
        S_LOAD,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP,
        P_PHI,
        P_GAP,
        P_PHI_BAR
    } phase_t;

    state_t state_q, state_d;
    phase_t phase_q, phase_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [NTX_BITS-1:0] sr_q, sr_d;
    logic [NTX_BITS-1:0] sr_shift;
    logic [BIT_CNT_WIDTH-1:0] nbits_q, nbits_d;
    logic id_q, id_d;
    logic phi_q, phi_d;
    logic bar_q, bar_d;
    logic sdi_q, sdi_d;
    logic load_q, load_d;
    logic done_q, done_d;
    logic phase_end;

    // Only the low NTX_BITS of the code word matter; the rest is ignored.
    logic unused_data;
    assign unused_data = ^data_in;

    // Sequencer: next state, sub-phase timing and registered scan outputs.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cyc_d    = cyc_q;
        sr_d     = sr_q;
        nbits_d  = nbits_q;
        id_d     = id_q;
        phi_d    = 1'b0;
        bar_d    = 1'b0;
        sdi_d    = sdi_q;
        load_d   = load_q;
        done_d   = done_q;
        sr_shift = sr_q << 1;
        phase_end = (cyc_q == CYC_LAST);

        unique case (state_q)
            S_CAPTURE: begin
                sr_d    = data_in[NTX_BITS-1:0];
                sdi_d   = data_in[NTX_BITS-1];
                id_d    = 1'b1;
                nbits_d = '0;
                phase_d = P_SETUP;
                cyc_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (!phase_end) begin
                    cyc_d = cyc_q + CYC_ONE;
                    phi_d = (phase_q == P_PHI);
                    bar_d = (phase_q == P_PHI_BAR);
                end else begin
                    cyc_d = '0;
                    unique case (phase_q)
                        P_SETUP: begin
                            phase_d = P_PHI;
                            phi_d   = 1'b1;
                        end
                        P_PHI: begin
                            phase_d = P_GAP;
                        end
                        P_GAP: begin
                            phase_d = P_PHI_BAR;
                            bar_d   = 1'b1;
                        end
                        P_PHI_BAR: begin
                            phase_d = P_SETUP;
                            nbits_d = nbits_q + CNT_ONE;
                            if (nbits_q == LAST_BIT) begin
                                state_d = S_LOAD;
                                id_d    = 1'b0;
                                sdi_d   = 1'b0;
                                load_d  = 1'b1;
                            end else begin
                                sr_d  = sr_shift;
                                sdi_d = sr_shift[NTX_BITS-1];
                            end
                        end
                    endcase
                end
            end
            S_LOAD: begin
                if (phase_end) begin
                    cyc_d   = '0;
                    load_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_CAPTURE;
            phase_q <= P_SETUP;
            cyc_q   <= '0;
            sr_q    <= '0;
            nbits_q <= '0;
            id_q    <= 1'b0;
            phi_q   <= 1'b0;
            bar_q   <= 1'b0;
            sdi_q   <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cyc_q   <= cyc_d;
            sr_q    <= sr_d;
            nbits_q <= nbits_d;
            id_q    <= id_d;
            phi_q   <= phi_d;
            bar_q   <= bar_d;
            sdi_q   <= sdi_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end

    assign scan_id        = id_q;
    assign scan_phi       = phi_q;
    assign scan_phi_bar   = bar_q;
    assign scan_data_in   = sdi_q;
    assign scan_load_chip = load_q;
    assign nbits_cnt      = nbits_q;
    assign scan_done      = done_q;

endmodule

// File: tb/tb_hop_scan_ctrl.sv
// tb_hop_scan_ctrl: directed bench for hop_scan_ctrl at default sizing
// and at SCAN_WIDTH=1, NTX_BITS=4.
module tb_hop_scan_ctrl;

    localparam int W   = 2;
    localparam int N   = 78;
    localparam int TX  = 128;
    localparam int BW  = 7;
    localparam int SN  = 4;
    localparam int STX = 8;
    localparam int SBW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic [TX-1:0] data_in = '0;
    logic          scan_id, scan_phi, scan_phi_bar, scan_data_in;
    logic          scan_load_chip, scan_done;
    logic [BW-1:0] nbits_cnt;

    logic           s_reset = 1'b0;
    logic [STX-1:0] s_data = '0;
    logic           s_id, s_phi, s_bar, s_sdi, s_load, s_done;
    logic [SBW-1:0] s_nbits;

    int checks = 0;
    int errors = 0;

    int bits_n, phi_pulses, bar_pulses, overlap, bad_width;
    int load_cyc, load_pulses, id_cyc, nb_bad, done_edge;
    logic serial [0:127];

    hop_scan_ctrl dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .scan_id(scan_id), .scan_phi(scan_phi),
        .scan_phi_bar(scan_phi_bar), .scan_data_in(scan_data_in),
        .scan_load_chip(scan_load_chip), .nbits_cnt(nbits_cnt),
        .scan_done(scan_done)
    );

    hop_scan_ctrl #(
        .SCAN_WIDTH(1), .NTX_BITS(SN),
        .TX_BITS_WIDTH(STX), .BIT_CNT_WIDTH(SBW)
    ) dut_s (
        .clk(clk), .reset(s_reset), .data_in(s_data),
        .scan_id(s_id), .scan_phi(s_phi),
        .scan_phi_bar(s_bar), .scan_data_in(s_sdi),
        .scan_load_chip(s_load), .nbits_cnt(s_nbits),
        .scan_done(s_done)
    );

    function automatic logic [12:0] outs();
        return {scan_id, scan_phi, scan_phi_bar, scan_data_in,
                scan_load_chip, nbits_cnt, scan_done};
    endfunction

    task automatic restart(input logic [TX-1:0] d);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        data_in = d;
        reset = 1'b1;
    endtask

    // Observe the main DUT from release until scan_done (bounded).
    task automatic collect(input int maxc, input bit tog);
        logic pphi, pbar, pload;
        int   pnb, phi_w, bar_w;
        bits_n = 0; phi_pulses = 0; bar_pulses = 0; overlap = 0;
        bad_width = 0; load_cyc = 0; load_pulses = 0; id_cyc = 0;
        nb_bad = 0; done_edge = -1;
        pphi = 0; pbar = 0; pload = 0; pnb = 0; phi_w = 0; bar_w = 0;
        for (int i = 0; i < 128; i++) serial[i] = 1'bx;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (scan_phi && scan_phi_bar) overlap++;
            if (scan_phi && !pphi) begin
                if (bits_n < 128) serial[bits_n] = scan_data_in;
                bits_n++;
                phi_pulses++;
                phi_w = 1;
            end else if (scan_phi) phi_w++;
            if (!scan_phi && pphi && phi_w != W) bad_width++;
            if (scan_phi_bar && !pbar) begin
                bar_pulses++;
                bar_w = 1;
            end else if (scan_phi_bar) bar_w++;
            if (!scan_phi_bar && pbar && bar_w != W) bad_width++;
            if (scan_load_chip) load_cyc++;
            if (scan_load_chip && !pload) load_pulses++;
            if (scan_id) id_cyc++;
            if (int'(nbits_cnt) < pnb || int'(nbits_cnt) > pnb + 1)
                nb_bad++;
            pphi = scan_phi; pbar = scan_phi_bar;
            pload = scan_load_chip; pnb = int'(nbits_cnt);
            if (tog) data_in = ~data_in;
            if (scan_done) begin
                done_edge = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        s_reset = 1'b0;
        data_in = {4{32'hDEADBEEF}};
        s_data = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 13'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %h want 0", c, outs());
            end
            checks++;
            if ({s_id, s_phi, s_bar, s_sdi, s_load, s_nbits, s_done}
                !== 9'd0) begin
                errors++;
                $display("FAIL reset_hold_small cyc %0d: nonzero", c);
            end
        end
    endtask

    task automatic check_run(input string nm, input logic [TX-1:0] d);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++)
            if (serial[i] !== d[N-1-i]) bad++;
        checks++;
        if (done_edge !== 627) begin
            errors++;
            $display("FAIL %s done_edge: got %0d want 627", nm, done_edge);
        end
        checks++;
        if (bits_n !== N || bad !== 0) begin
            errors++;
            $display("FAIL %s serial: bits %0d bad %0d want %0d/0",
                     nm, bits_n, bad, N);
        end
        checks++;
        if (phi_pulses !== N || bar_pulses !== N) begin
            errors++;
            $display("FAIL %s pulses: phi %0d bar %0d want %0d",
                     nm, phi_pulses, bar_pulses, N);
        end
        checks++;
        if (overlap !== 0 || bad_width !== 0) begin
            errors++;
            $display("FAIL %s phase: overlap %0d badw %0d want 0/0",
                     nm, overlap, bad_width);
        end
        checks++;
        if (load_pulses !== 1 || load_cyc !== W) begin
            errors++;
            $display("FAIL %s load: pulses %0d cyc %0d want 1/%0d",
                     nm, load_pulses, load_cyc, W);
        end
        checks++;
        if (id_cyc !== 624) begin
            errors++;
            $display("FAIL %s scan_id: got %0d want 624", nm, id_cyc);
        end
        checks++;
        if (nb_bad !== 0 || nbits_cnt !== BW'(N)) begin
            errors++;
            $display("FAIL %s nbits: bad %0d final %0d want 0/%0d",
                     nm, nb_bad, nbits_cnt, N);
        end
    endtask

    task automatic test_default_run;
        logic [TX-1:0] d;
        d = 128'hA5A5_A5A5;
        restart(d);
        collect(700, 1'b0);
        check_run("default", d);
        repeat (5) @(negedge clk);
        checks++;
        if (scan_done !== 1'b1 || outs() !== {6'd0, BW'(N), 1'b1}) begin
            errors++;
            $display("FAIL done_hold: got %h", outs());
        end
    endtask

    task automatic test_small;
        logic sb [0:7];
        int   nb, idc, ldc, de;
        logic pphi;
        nb = 0; idc = 0; ldc = 0; de = -1; pphi = 0;
        @(negedge clk);
        s_data = 8'hFB;
        s_reset = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (s_phi && !pphi && nb < 8) begin
                sb[nb] = s_sdi;
                nb++;
            end
            pphi = s_phi;
            if (s_id) idc++;
            if (s_load) ldc++;
            if (s_done) begin
                de = c;
                break;
            end
        end
        checks++;
        if (nb !== 4 || {sb[0], sb[1], sb[2], sb[3]} !== 4'b1011) begin
            errors++;
            $display("FAIL small_serial: n %0d bits %b%b%b%b want 1011",
                     nb, sb[0], sb[1], sb[2], sb[3]);
        end
        checks++;
        if (idc !== 16 || ldc !== 1) begin
            errors++;
            $display("FAIL small_len: id %0d load %0d want 16/1", idc, ldc);
        end
        checks++;
        if (de !== 18 || s_nbits !== 3'd4) begin
            errors++;
            $display("FAIL small_done: edge %0d nbits %0d want 18/4",
                     de, s_nbits);
        end
    endtask

    task automatic test_mid_reset;
        logic [TX-1:0] d;
        restart(128'hA5A5_A5A5);
        repeat (300) @(negedge clk);
        checks++;
        if (scan_id !== 1'b1) begin
            errors++;
            $display("FAIL mid_active: scan_id %b want 1", scan_id);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (outs() !== 13'd0) begin
            errors++;
            $display("FAIL mid_async: got %h want 0", outs());
        end
        repeat (5) @(negedge clk);
        d = 128'h1;
        data_in = d;
        reset = 1'b1;
        collect(700, 1'b0);
        check_run("restart", d);
    endtask

    task automatic test_toggle;
        logic [TX-1:0] d0;
        d0 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        restart(d0);
        collect(700, 1'b1);
        check_run("toggle", d0);
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_small();
        test_mid_reset();
        test_toggle();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
